// File: rtl/s510_cnt_gen_if.sv
// Control inputs and decode outputs of the s510 line/pixel counter generator.
// The master drives the clear/increment requests; the slave is the counter block.
interface s510_cnt_gen_if;
    logic cclr;
    logic pclr;
    logic pc;

    logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272;
    logic cnt283, cnt284, cnt509, cnt511, cnt567, cnt591;
    logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;
    logic field;
    logic cnt_ovf;

    modport master (
        output cclr, pclr, pc,
        input  cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
        input  cnt283, cnt284, cnt509, cnt511, cnt567, cnt591,
        input  pcnt6, pcnt12, pcnt17, pcnt27, pcnt241,
        input  field, cnt_ovf
    );

    modport slave (
        input  cclr, pclr, pc,
        output cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
        output cnt283, cnt284, cnt509, cnt511, cnt567, cnt591,
        output pcnt6, pcnt12, pcnt17, pcnt27, pcnt241,
        output field, cnt_ovf
    );
endinterface

// File: rtl/s510_cnt_gen.sv
// Line/pixel counter with registered decode strobes and a field parity bit.
// Optional sticky line-wrap flag is enabled by defining S510_CNT_OVF_EN.
module s510_cnt_gen #(
    parameter int CW = 10,
    parameter int PW = 8
) (
    input logic            CK,
    input logic            RN,
    s510_cnt_gen_if.slave  bus
);

    localparam int NCNT  = 13;
    localparam int NPCNT = 5;
    localparam int CNT_DEC  [NCNT]  = '{10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};
    localparam int PCNT_DEC [NPCNT] = '{6, 12, 17, 27, 241};

    logic [CW-1:0]    cnt, cnt_next;
    logic [PW-1:0]    pcnt, pcnt_next;
    logic [NCNT-1:0]  cnt_dec;
    logic [NPCNT-1:0] pcnt_dec;
    logic             field_q;

    always_comb begin
        cnt_next  = cnt;
        pcnt_next = pcnt;
        if (bus.cclr)
            cnt_next = '0;
        else if (bus.pclr)
            cnt_next = cnt + 1'b1;
        if (bus.pclr)
            pcnt_next = '0;
        else if (bus.pc)
            pcnt_next = pcnt + 1'b1;
    end

    // Strobes are decoded from the next-state value so they line up with the counter registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt      <= '0;
            pcnt     <= '0;
            cnt_dec  <= '0;
            pcnt_dec <= '0;
            field_q  <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            pcnt <= pcnt_next;
            for (int i = 0; i < NCNT; i++)
                cnt_dec[i] <= (cnt_next == CW'(CNT_DEC[i]));
            for (int j = 0; j < NPCNT; j++)
                pcnt_dec[j] <= (pcnt_next == PW'(PCNT_DEC[j]));
            if (bus.cclr)
                field_q <= ~field_q;
        end
    end

`ifdef S510_CNT_OVF_EN
    logic ovf_q;
    logic wrap;

    assign wrap = !bus.cclr && bus.pclr && (cnt == '1);

    // A clear on the same edge as a wrap wins, leaving the flag low.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            ovf_q <= 1'b0;
        else if (bus.cclr)
            ovf_q <= 1'b0;
        else if (wrap)
            ovf_q <= 1'b1;
    end

    assign bus.cnt_ovf = ovf_q;
`else
    assign bus.cnt_ovf = 1'b0;
`endif

    assign bus.cnt10  = cnt_dec[0];
    assign bus.cnt13  = cnt_dec[1];
    assign bus.cnt21  = cnt_dec[2];
    assign bus.cnt44  = cnt_dec[3];
    assign bus.cnt45  = cnt_dec[4];
    assign bus.cnt261 = cnt_dec[5];
    assign bus.cnt272 = cnt_dec[6];
    assign bus.cnt283 = cnt_dec[7];
    assign bus.cnt284 = cnt_dec[8];
    assign bus.cnt509 = cnt_dec[9];
    assign bus.cnt511 = cnt_dec[10];
    assign bus.cnt567 = cnt_dec[11];
    assign bus.cnt591 = cnt_dec[12];

    assign bus.pcnt6   = pcnt_dec[0];
    assign bus.pcnt12  = pcnt_dec[1];
    assign bus.pcnt17  = pcnt_dec[2];
    assign bus.pcnt27  = pcnt_dec[3];
    assign bus.pcnt241 = pcnt_dec[4];

    assign bus.field = field_q;

endmodule

// File: tb/tb_s510_cnt_gen.sv
// Directed testbench for s510_cnt_gen: a reference counter model predicts every
// strobe, field and cnt_ovf after each clock; explicit checks mark the key events.
module tb_s510_cnt_gen;

`ifdef S510_CNT_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    localparam int CNT_VALS  [13] = '{10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};
    localparam int PCNT_VALS [5]  = '{6, 12, 17, 27, 241};

    logic ck = 1'b0;
    logic rn = 1'b1;

    s510_cnt_gen_if bus ();

    s510_cnt_gen #(.CW(10), .PW(8)) dut (
        .CK  (ck),
        .RN  (rn),
        .bus (bus)
    );

    always #5 ck = ~ck;

    int   tests_run  = 0;
    int   fail_count = 0;
    int   cnt_m      = 0;
    int   pcnt_m     = 0;
    logic field_m    = 1'b0;
    logic ovf_m      = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [12:0] co;
        logic [4:0]  po;
        co = {bus.cnt591, bus.cnt567, bus.cnt511, bus.cnt509, bus.cnt284, bus.cnt283,
              bus.cnt272, bus.cnt261, bus.cnt45, bus.cnt44, bus.cnt21, bus.cnt13, bus.cnt10};
        po = {bus.pcnt241, bus.pcnt27, bus.pcnt17, bus.pcnt12, bus.pcnt6};
        for (int i = 0; i < 13; i++)
            check_bit($sformatf("cnt%0d(cnt=%0d)", CNT_VALS[i], cnt_m), co[i], cnt_m == CNT_VALS[i]);
        for (int i = 0; i < 5; i++)
            check_bit($sformatf("pcnt%0d(pcnt=%0d)", PCNT_VALS[i], pcnt_m), po[i], pcnt_m == PCNT_VALS[i]);
        check_bit("field", bus.field, field_m);
        check_bit("cnt_ovf", bus.cnt_ovf, ovf_m);
    endtask

    // Drive one cycle of requests, advance the model at the edge, then check 1 time unit later.
    task automatic apply_stimulus(input logic c, input logic p, input logic i);
        bus.cclr = c;
        bus.pclr = p;
        bus.pc   = i;
        @(posedge ck);
        if (c) begin
            cnt_m   = 0;
            field_m = ~field_m;
            ovf_m   = 1'b0;
        end else if (p) begin
            if (cnt_m == 1023)
                ovf_m = OVF_EN;
            cnt_m = (cnt_m + 1) % 1024;
        end
        if (p)
            pcnt_m = 0;
        else if (i)
            pcnt_m = (pcnt_m + 1) % 256;
        #1;
        check_output();
    endtask

    initial begin
        bus.cclr = 1'b0;
        bus.pclr = 1'b0;
        bus.pc   = 1'b0;

        #1 rn = 1'b0;
        #2;
        check_output();
        @(posedge ck);
        #1;
        check_output();
        rn = 1'b1;

        repeat (27) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_bit("pcnt27_at_27", bus.pcnt27, 1'b1);
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_bit("pcnt27_hold", bus.pcnt27, 1'b1);

        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_bit("pclr_over_pc",
                  |{bus.pcnt6, bus.pcnt12, bus.pcnt17, bus.pcnt27, bus.pcnt241}, 1'b0);

        // Pixel wrap must leave the line counter alone.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (256) apply_stimulus(1'b0, 1'b0, 1'b1);
        repeat (6) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_bit("pcnt6_after_wrap", bus.pcnt6, 1'b1);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (591) apply_stimulus(1'b0, 1'b1, 1'b0);
        check_bit("cnt591_after_591", bus.cnt591, 1'b1);

        repeat (1023 - 591) apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_bit("ovf_after_wrap", bus.cnt_ovf, OVF_EN);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_bit("ovf_sticky", bus.cnt_ovf, OVF_EN);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_bit("ovf_cleared", bus.cnt_ovf, 1'b0);

        repeat (1023) apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_bit("ovf_clr_wins", bus.cnt_ovf, 1'b0);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (283) apply_stimulus(1'b0, 1'b1, 1'b1);
        repeat (6) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_bit("cnt283_set", bus.cnt283, 1'b1);
        check_bit("pcnt6_at_283", bus.pcnt6, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_bit("cnt283_fall", bus.cnt283, 1'b0);
        check_bit("pcnt6_fall", bus.pcnt6, 1'b0);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (509) apply_stimulus(1'b0, 1'b1, 1'b0);
        repeat (241) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_bit("cnt509_pre_reset", bus.cnt509, 1'b1);
        check_bit("pcnt241_pre_reset", bus.pcnt241, 1'b1);
        check_bit("field_pre_reset", bus.field, 1'b1);

        // Asynchronous reset between edges: outputs must drop before the next rise.
        #2 rn = 1'b0;
        cnt_m   = 0;
        pcnt_m  = 0;
        field_m = 1'b0;
        ovf_m   = 1'b0;
        #1;
        check_bit("cnt509_async", bus.cnt509, 1'b0);
        check_bit("pcnt241_async", bus.pcnt241, 1'b0);
        check_bit("field_async", bus.field, 1'b0);
        check_output();
        @(posedge ck);
        #1 rn = 1'b1;

        repeat (6) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_bit("pcnt6_after_reset", bus.pcnt6, 1'b1);
        repeat (10) apply_stimulus(1'b0, 1'b1, 1'b0);
        check_bit("cnt10_after_reset", bus.cnt10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/s510_cnt_gen.md
S510_CNT_GEN -- requirements
Module: s510_cnt_gen

Interface
REQ-001 Parameter CW, default 10: line counter width; SHALL be >= 10.
REQ-002 Parameter PW, default 8: pixel counter width; SHALL be >= 8.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CK  in  1  clock; all state updates on its rising edge.
REQ-005 RN  in  1  asynchronous active-low reset.
REQ-006 cclr  in  1  line counter clear request, sampled at CK rise.
REQ-007 pclr  in  1  pixel counter clear / end-of-line request, sampled at CK rise.
REQ-008 pc  in  1  pixel counter increment request, sampled at CK rise.
REQ-009 cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284, cnt509, cnt511, cnt567, cnt591  out  1 each  line-count decode strobes.
REQ-010 pcnt6, pcnt12, pcnt17, pcnt27, pcnt241  out  1 each  pixel-count decode strobes.
REQ-011 field  out  1  field parity bit.
REQ-012 cnt_ovf  out  1  sticky line counter wrap flag; see Configuration.

Function
REQ-013 Pixel counter pcnt (PW bits): pclr=1 -> 0; else pc=1 -> pcnt+1 modulo 2^PW; else hold.
REQ-014 pclr SHALL take priority over pc when both are 1.
REQ-015 Line counter cnt (CW bits): cclr=1 -> 0; else pclr=1 -> cnt+1 modulo 2^CW; else hold.
REQ-016 cclr SHALL take priority over pclr when both are 1; pcnt is still cleared that cycle.
REQ-017 Each strobe cntN SHALL be 1 exactly in the cycles where the cnt register equals N.
REQ-018 Each strobe pcntN SHALL be 1 exactly in the cycles where the pcnt register equals N.
REQ-019 Strobes SHALL be flop outputs, decoded from the next-state counter value.
REQ-020 As a result, strobes have zero latency relative to the counter registers and no combinational path from inputs to outputs.
REQ-021 field SHALL toggle on every CK rise with cclr=1.
REQ-022 Wrap boundaries:
- cnt at 2^CW-1 with pclr=1 and cclr=0 -> cnt becomes 0.
- pcnt at 2^PW-1 with pc=1 and pclr=0 -> pcnt becomes 0.
- Neither wrap SHALL have any side effect on the other counter.
REQ-023 No decode value SHALL equal 0, so all strobes are 0 while the matching counter is 0.

Reset
REQ-024 RN=0 SHALL immediately, without a clock edge, force the following to 0: cnt, pcnt, field, cnt_ovf and every strobe.
REQ-025 Reset asserted mid-count SHALL discard the count; counting resumes from 0 on the first CK rise after RN returns to 1.
REQ-026 Deassertion of RN SHALL be synchronised externally; the block adds no reset synchroniser.

Configuration
REQ-027 With macro S510_CNT_OVF_EN defined:
- cnt_ovf is set to 1 on the CK rise where cnt wraps from 2^CW-1 to 0 by increment (cclr=0).
- cnt_ovf holds until a CK rise with cclr=1 clears it.
- If a wrap and cclr=1 occur on the same edge, cclr wins and cnt_ovf becomes 0.
REQ-028 With S510_CNT_OVF_EN undefined, cnt_ovf SHALL be constant 0 and no overflow flop SHALL exist; all other behaviour is unchanged.

Verification
REQ-029 Release RN with pclr=0, then apply pc=1 for 27 cycles -> pcnt6 high on exactly one cycle (pcnt=6), likewise pcnt12, pcnt17, pcnt27; after pc drops, pcnt27 stays 1.
REQ-030 Apply pc=1 and pclr=1 together -> pcnt=0; no pcnt strobe asserts.
REQ-031 Apply cclr=1 once, then 591 pclr pulses -> each cnt strobe asserts at the matching pulse count, with cnt591 high after pulse 591; field toggled once.
REQ-032 Preload cnt to 1023 via 1023 pclr pulses, then one more pclr -> cnt=0; with S510_CNT_OVF_EN defined cnt_ovf=1, without it cnt_ovf=0. A following cclr clears the flag.
REQ-033 Drive cclr=1 and pclr=1 together at cnt=283 -> cnt=0, pcnt=0, cnt283 falls to 0, field toggles.
REQ-034 Assert RN=0 mid-cycle at cnt=509 and pcnt=241 -> cnt509, pcnt241, field and cnt_ovf go to 0 before the next CK rise.
